// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline stall controller.
//            It holds the controller state encoding, the default register
//            address width, and a bundle of the five pipeline register
//            enables plus the two bubble flushes.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int c_REG_ADDR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    typedef struct packed {
        logic en_pc;
        logic en_if_id;
        logic en_id_ex;
        logic en_ex_mem;
        logic en_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } ctrl_t;

    // Whole pipeline frozen: nothing loads, nothing flushes.
    localparam ctrl_t c_CTRL_FREEZE = '{default: 1'b0};

    // Normal advance of every stage.
    localparam ctrl_t c_CTRL_RUN = '{en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1,
                                     en_ex_mem: 1'b1, en_mem_wb: 1'b1,
                                     flush_if_id: 1'b0, flush_id_ex: 1'b0};

    // Taken branch: everything advances, both younger stages become bubbles.
    localparam ctrl_t c_CTRL_SQUASH = '{en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1,
                                        en_ex_mem: 1'b1, en_mem_wb: 1'b1,
                                        flush_if_id: 1'b1, flush_id_ex: 1'b1};

    // Load-use: PC and IF/ID hold, a bubble enters ID/EX, the back end drains.
    localparam ctrl_t c_CTRL_BUBBLE = '{en_pc: 1'b0, en_if_id: 1'b0, en_id_ex: 1'b1,
                                        en_ex_mem: 1'b1, en_mem_wb: 1'b1,
                                        flush_if_id: 1'b0, flush_id_ex: 1'b1};

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_controller_if
// Purpose  : Hazard inputs gathered from the datapath and the resulting
//            pipeline register controls.
//   slave  : the stall controller (reads hazards, drives enables/flushes,
//            halted and stall_count).
//   master : the datapath side (drives hazards, reads controls).
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_stall_controller_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = c_REG_ADDR_W_DEFAULT,
    parameter int CNT_W      = 32
);

    logic                  mem_req;
    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic [REG_ADDR_W-1:0] if_id_rs1;
    logic [REG_ADDR_W-1:0] if_id_rs2;
    logic                  if_id_uses_rs1;
    logic                  if_id_uses_rs2;
    logic                  ex_branch_taken;
    logic                  wb_halt;

    logic                  en_pc;
    logic                  en_if_id;
    logic                  en_id_ex;
    logic                  en_ex_mem;
    logic                  en_mem_wb;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  halted;
    logic [CNT_W-1:0]      stall_count;

    modport slave (
        input  mem_req, id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_uses_rs1, if_id_uses_rs2, ex_branch_taken, wb_halt,
        output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, halted, stall_count
    );

    modport master (
        output mem_req, id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_uses_rs1, if_id_uses_rs2, ex_branch_taken, wb_halt,
        input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, halted, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Combinational compare of a producing destination register
//            against the source registers of a consumer.
//   i_mem_read          producer is a load
//   i_rd                producer destination register
//   i_rs1 / i_rs2       consumer source registers
//   i_uses_rs1/_rs2     consumer actually reads that source
//   o_hazard            consumer depends on the load result
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_ADDR_W = 4
) (
    input  wire logic                  i_mem_read,
    input  wire logic [REG_ADDR_W-1:0] i_rd,
    input  wire logic [REG_ADDR_W-1:0] i_rs1,
    input  wire logic [REG_ADDR_W-1:0] i_rs2,
    input  wire logic                  i_uses_rs1,
    input  wire logic                  i_uses_rs2,
    output logic                       o_hazard
);

    logic w_match_rs1;
    logic w_match_rs2;

    assign w_match_rs1 = i_uses_rs1 && (i_rs1 == i_rd);
    assign w_match_rs2 = i_uses_rs2 && (i_rs2 == i_rd);

    // Register 0 is hardwired to zero, so a write to it never creates a dependency.
    assign o_hazard = i_mem_read && (i_rd != '0) && (w_match_rs1 || w_match_rs2);

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_controller
// Purpose  : Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables
//            and the IF/ID, ID/EX bubble flushes. Freezes for MEM_LAT cycles
//            per memory operation, inserts one bubble per load-use hazard,
//            squashes wrong-path work on a taken branch and halts on HALT.
//            Keeps a saturating stall-cycle counter.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : hazard inputs and control outputs (slave modport)
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = c_REG_ADDR_W_DEFAULT,
    parameter int MEM_LAT    = 2,
    parameter int CNT_W      = 32
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    pipeline_stall_controller_if.slave  bus
);

    localparam int c_WAIT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [c_WAIT_W-1:0] c_LAT_M1 = c_WAIT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_WAIT_W-1:0] r_cnt;
    logic [c_WAIT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0]    r_stall_count;
    ctrl_t               w_ctrl;
    logic                w_halted;
    logic                w_hazard;
    logic                w_halt_detect;
    logic                w_stall_cycle;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .i_mem_read (bus.id_ex_mem_read),
        .i_rd       (bus.id_ex_rd),
        .i_rs1      (bus.if_id_rs1),
        .i_rs2      (bus.if_id_rs2),
        .i_uses_rs1 (bus.if_id_uses_rs1),
        .i_uses_rs2 (bus.if_id_uses_rs2),
        .o_hazard   (w_hazard)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ctrl       = c_CTRL_FREEZE;
        w_halted     = 1'b0;
        case (r_state)
            HALTED: begin
                w_halted = 1'b1;
            end
            default: begin
                if (bus.wb_halt) begin
                    w_state_next = HALTED;
                end else if ((r_state == MEM_WAIT) && (r_cnt != '0)) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if ((r_state == RUN) && bus.mem_req && (MEM_LAT > 0)) begin
                    // The entry cycle is itself the first stall cycle.
                    w_cnt_next   = c_LAT_M1;
                    w_state_next = MEM_WAIT;
                end else begin
                    // RUN without memory stall, or the MEM_WAIT release cycle
                    // (where mem_req belongs to the operation just finished).
                    w_state_next = RUN;
                    if (bus.ex_branch_taken) begin
                        w_ctrl = c_CTRL_SQUASH;
                    end else if (w_hazard) begin
                        w_ctrl = c_CTRL_BUBBLE;
                    end else begin
                        w_ctrl = c_CTRL_RUN;
                    end
                end
            end
        endcase
        if (reset) begin
            w_ctrl   = c_CTRL_FREEZE;
            w_halted = 1'b0;
        end
    end

    // The cycle that detects HALT freezes the pipe but is not a stall.
    assign w_halt_detect = (r_state != HALTED) && bus.wb_halt;
    assign w_stall_cycle = !w_ctrl.en_pc && (r_state != HALTED) && !w_halt_detect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall_cycle && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.en_pc       = w_ctrl.en_pc;
    assign bus.en_if_id    = w_ctrl.en_if_id;
    assign bus.en_id_ex    = w_ctrl.en_id_ex;
    assign bus.en_ex_mem   = w_ctrl.en_ex_mem;
    assign bus.en_mem_wb   = w_ctrl.en_mem_wb;
    assign bus.flush_if_id = w_ctrl.flush_if_id;
    assign bus.flush_id_ex = w_ctrl.flush_id_ex;
    assign bus.halted      = w_halted;
    assign bus.stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_controller
// Purpose  : Self-checking bench for pipeline_stall_controller. A table of
//            per-cycle vectors (MEM_LAT=2, CNT_W=32) runs through a
//            scoreboard; a second instance with CNT_W=4 checks saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    typedef struct {
        int rst;
        int mreq;
        int mrd;
        int rd;
        int rs1;
        int rs2;
        int u1;
        int u2;
        int br;
        int halt;
        int en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        int fl;   // {if_id, id_ex}
        int h;
        int sc;
    } vec_t;

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] sc;
        int          idx;
    } exp_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset4 = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs[$];
    exp_t sb[$];

    pipeline_stall_controller_if #(.REG_ADDR_W(4), .CNT_W(32)) bus0 ();
    pipeline_stall_controller_if #(.REG_ADDR_W(4), .CNT_W(4))  bus4 ();

    pipeline_stall_controller #(
        .REG_ADDR_W (4),
        .MEM_LAT    (2),
        .CNT_W      (32)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    pipeline_stall_controller #(
        .REG_ADDR_W (4),
        .MEM_LAT    (2),
        .CNT_W      (4)
    ) u_dut_sat (
        .clk   (clk),
        .reset (reset4),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    task automatic add(input int rst, input int mreq, input int mrd, input int rd,
                       input int rs1, input int rs2, input int u1, input int u2,
                       input int br, input int halt, input int en, input int fl,
                       input int h, input int sc);
        vec_t v;
        v = '{rst, mreq, mrd, rd, rs1, rs2, u1, u2, br, halt, en, fl, h, sc};
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs after the edge, queue the expectation, and
    // compare at the falling edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        logic [7:0] act;
        @(posedge clk);
        #1;
        reset                = (v.rst != 0);
        bus0.mem_req         = (v.mreq != 0);
        bus0.id_ex_mem_read  = (v.mrd != 0);
        bus0.id_ex_rd        = 4'(v.rd);
        bus0.if_id_rs1       = 4'(v.rs1);
        bus0.if_id_rs2       = 4'(v.rs2);
        bus0.if_id_uses_rs1  = (v.u1 != 0);
        bus0.if_id_uses_rs2  = (v.u2 != 0);
        bus0.ex_branch_taken = (v.br != 0);
        bus0.wb_halt         = (v.halt != 0);
        e.ctrl = {5'(v.en), 2'(v.fl), 1'(v.h)};
        e.sc   = 32'(v.sc);
        e.idx  = idx;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        act = {bus0.en_pc, bus0.en_if_id, bus0.en_id_ex, bus0.en_ex_mem, bus0.en_mem_wb,
               bus0.flush_if_id, bus0.flush_id_ex, bus0.halted};
        n_cmp++;
        if (act !== got.ctrl) begin
            n_err++;
            $display("FAIL ctrl vec %0d: got en/fl/h=%b required %b", got.idx, act, got.ctrl);
        end
        n_cmp++;
        if (bus0.stall_count !== got.sc) begin
            n_err++;
            $display("FAIL stall_count vec %0d: got %0d required %0d",
                     got.idx, bus0.stall_count, got.sc);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] want);
        n_cmp++;
        if (bus4.stall_count !== want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, bus4.stall_count, want);
        end
    endtask

    initial begin
        bus0.mem_req = 0; bus0.id_ex_mem_read = 0; bus0.id_ex_rd = 0;
        bus0.if_id_rs1 = 0; bus0.if_id_rs2 = 0; bus0.if_id_uses_rs1 = 0;
        bus0.if_id_uses_rs2 = 0; bus0.ex_branch_taken = 0; bus0.wb_halt = 0;
        bus4.mem_req = 0; bus4.id_ex_mem_read = 0; bus4.id_ex_rd = 0;
        bus4.if_id_rs1 = 0; bus4.if_id_rs2 = 0; bus4.if_id_uses_rs1 = 0;
        bus4.if_id_uses_rs2 = 0; bus4.ex_branch_taken = 0; bus4.wb_halt = 0;

        //  rst mreq mrd rd rs1 rs2 u1 u2 br halt  en        fl     h  sc
        add(1,  0,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 0, 0);  // in reset
        add(0,  0,   0,  0, 0,  0,  0, 0, 0, 0,    5'b11111, 2'b00, 0, 0);  // normal
        add(0,  1,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 0, 0);  // mem stall entry
        add(0,  1,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 0, 1);  // mem wait
        add(0,  1,   0,  0, 0,  0,  0, 0, 0, 0,    5'b11111, 2'b00, 0, 2);  // release, mem_req ignored
        add(0,  0,   0,  0, 0,  0,  0, 0, 0, 0,    5'b11111, 2'b00, 0, 2);
        add(0,  0,   1,  5, 0,  5,  0, 1, 0, 0,    5'b00111, 2'b01, 0, 2);  // load-use on rs2
        add(0,  0,   0,  0, 0,  0,  0, 0, 0, 0,    5'b11111, 2'b00, 0, 3);
        add(0,  0,   1,  0, 0,  0,  0, 1, 0, 0,    5'b11111, 2'b00, 0, 3);  // rd=0 never hazards
        add(0,  0,   1,  5, 0,  5,  0, 0, 0, 0,    5'b11111, 2'b00, 0, 3);  // rs2 not used
        add(0,  0,   0,  7, 7,  0,  1, 0, 0, 0,    5'b11111, 2'b00, 0, 3);  // not a load
        add(0,  0,   1,  7, 7,  0,  1, 0, 0, 0,    5'b00111, 2'b01, 0, 3);  // load-use on rs1
        add(0,  0,   1,  5, 0,  5,  0, 1, 1, 0,    5'b11111, 2'b11, 0, 4);  // branch beats load-use
        add(0,  0,   0,  0, 0,  0,  0, 0, 1, 0,    5'b11111, 2'b11, 0, 4);  // branch alone
        add(0,  1,   0,  0, 0,  0,  0, 0, 1, 0,    5'b00000, 2'b00, 0, 4);  // mem beats branch
        add(0,  0,   0,  0, 0,  0,  0, 0, 1, 0,    5'b00000, 2'b00, 0, 5);
        add(0,  0,   0,  0, 0,  0,  0, 0, 1, 0,    5'b11111, 2'b11, 0, 6);  // branch on release
        add(0,  1,   1,  5, 0,  5,  0, 1, 0, 0,    5'b00000, 2'b00, 0, 6);  // mem beats load-use
        add(0,  0,   1,  5, 0,  5,  0, 1, 0, 0,    5'b00000, 2'b00, 0, 7);
        add(0,  1,   1,  5, 0,  5,  0, 1, 0, 0,    5'b00111, 2'b01, 0, 8);  // load-use on release
        add(0,  1,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 0, 9);  // back-to-back mem
        add(0,  1,   0,  0, 0,  0,  0, 0, 0, 1,    5'b00000, 2'b00, 0, 10); // halt during wait
        add(0,  1,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 1, 10); // halted
        add(0,  0,   0,  0, 0,  0,  0, 0, 1, 0,    5'b00000, 2'b00, 1, 10);
        add(0,  1,   1,  5, 0,  5,  0, 1, 0, 0,    5'b00000, 2'b00, 1, 10);
        add(1,  1,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 0, 0);  // reset from HALTED
        add(0,  0,   0,  0, 0,  0,  0, 0, 0, 0,    5'b11111, 2'b00, 0, 0);
        add(0,  1,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 0, 0);
        add(1,  0,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 0, 0);  // reset mid-wait
        add(0,  0,   0,  0, 0,  0,  0, 0, 0, 0,    5'b11111, 2'b00, 0, 0);  // no residual stall
        add(0,  0,   0,  0, 0,  0,  0, 0, 0, 1,    5'b00000, 2'b00, 0, 0);  // halt from RUN
        add(0,  0,   0,  0, 0,  0,  0, 0, 0, 0,    5'b00000, 2'b00, 1, 0);

        foreach (vecs[i]) apply(vecs[i], i);

        // HALTED ignores a toggling mem_req.
        for (int k = 0; k < 4; k++) begin
            vec_t v;
            v = '{0, k % 2, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 0};
            apply(v, 100 + k);
        end

        // Saturation on the CNT_W=4 instance: mem_req held high stalls two
        // of every three cycles.
        @(posedge clk);
        #1;
        reset4       = 1'b0;
        bus4.mem_req = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        chk4("sat_before_top", 4'd14);
        @(posedge clk);
        #1;
        chk4("sat_at_top", 4'd15);
        repeat (8) @(posedge clk);
        #1;
        chk4("sat_hold", 4'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Drives the enable and flush controls of the processor's pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) from hazard information gathered across the stages.
- Freezes the pipeline for fixed-latency memory operations, inserts bubbles on load-use hazards, squashes wrong-path instructions on a taken branch, and halts the core on a HALT instruction.
- Sits beside the datapath in the processor top level.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_ADDR_W, 4, register-address width.
- MEM_LAT, 2, stall cycles per memory operation in MEM; 0 means no stall.
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  in  1  EX/MEM holds a load or store.
- id_ex_mem_read  in  1  ID/EX holds a load.
- id_ex_rd  in  REG_ADDR_W  destination register of ID/EX.
- if_id_rs1  in  REG_ADDR_W  source 1 of the instruction in IF/ID.
- if_id_rs2  in  REG_ADDR_W  source 2 of the instruction in IF/ID.
- if_id_uses_rs1  in  1  rs1 is actually read.
- if_id_uses_rs2  in  1  rs2 is actually read.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- wb_halt  in  1  MEM/WB holds HALT.
- en_pc  out  1  PC register enable.
- en_if_id  out  1  IF/ID register enable.
- en_id_ex  out  1  ID/EX register enable.
- en_ex_mem  out  1  EX/MEM register enable.
- en_mem_wb  out  1  MEM/WB register enable.
- flush_if_id  out  1  IF/ID loads zero (bubble) on the next edge; meaningful only with en_if_id=1.
- flush_id_ex  out  1  ID/EX loads zero (bubble) on the next edge; meaningful only with en_id_ex=1.
- halted  out  1  core halted.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Registered state: state {RUN, MEM_WAIT, HALTED}, wait counter cnt (width clog2(MEM_LAT+1), minimum 1), stall_count.
- Outputs are combinational from state, cnt and inputs.
- Reset, asynchronous:
  - state=RUN, cnt=0, stall_count=0.
  - While reset=1, force all en_*=0, flush_*=0, halted=0.
  - Reset asserted mid-wait or while HALTED returns to RUN with no residual stall.
- Priority within RUN and MEM_WAIT, highest first: halt > memory stall > branch flush > load-use > normal.
- Halt: wb_halt=1 in RUN or MEM_WAIT drives all en=0 and flush=0, next state=HALTED.
- HALTED: all en=0, flush=0, halted=1. Only reset exits; all inputs are ignored.
- Memory stall entry, RUN with mem_req=1 and MEM_LAT>0:
  - All en=0, flush=0.
  - cnt<=MEM_LAT-1, state<=MEM_WAIT.
- MEM_WAIT with cnt!=0: all en=0, cnt<=cnt-1.
- MEM_WAIT with cnt==0 (release cycle):
  - mem_req is ignored; the rest of the RUN logic is applied.
  - state<=RUN.
- Each memory operation therefore costs exactly MEM_LAT stall cycles. A new mem_req in the following RUN cycle stalls again.
- Branch, ex_branch_taken=1 with no higher event:
  - All en=1, flush_if_id=1, flush_id_ex=1.
  - A simultaneous load-use hazard is discarded, since its instruction is squashed.
  - A branch held during a memory stall resolves on the release cycle.
- Load-use: hazard = id_ex_mem_read & (id_ex_rd!=0) & ((if_id_uses_rs1 & rs1==rd) | (if_id_uses_rs2 & rs2==rd)).
  - Register 0 never hazards.
  - On hazard: en_pc=0, en_if_id=0, en_id_ex=1, flush_id_ex=1, en_ex_mem=1, en_mem_wb=1, flush_if_id=0.
  - Exactly one bubble per hazard.
- Normal operation: all en=1, flush=0.
- stall_count:
  - Increments on every edge where reset=0, state!=HALTED and en_pc=0. This covers memory-stall cycles, load-use cycles and the halt-detect cycle is excluded.
  - Saturates at all-ones; never wraps.
- Rule: no flush is asserted while its register's enable=0.

Decomposition:
- pipeline_ctrl_pkg holds: the state enum (RUN, MEM_WAIT, HALTED), the default REG_ADDR_W, and a struct bundling the five enables and two flushes.
- One sub-module, load_use_detect: combinational hazard compare. It is reused later for forwarding checks.

Test Plan:
- Reset release with all inputs 0 → all en=1, flush=0, halted=0, stall_count=0.
- MEM_LAT=2, mem_req=1 for 3 cycles → en=0 for 2 cycles, then all en=1 on the 3rd cycle; stall_count=2.
- Load-use with id_ex_mem_read=1, rd=5, rs2=5, uses_rs2=1 → one cycle of en_pc=0, en_if_id=0, flush_id_ex=1, stall_count+1. Repeat with rd=0 or uses_rs2=0 → no stall.
- ex_branch_taken=1 together with a load-use hazard → all en=1, flush_if_id=1, flush_id_ex=1, stall_count unchanged.
- wb_halt=1 during MEM_WAIT → all en=0 forever and halted=1, with mem_req toggling. Reset then returns to RUN and clears stall_count to 0.
- Force stall_count to all-ones (CNT_W=4 build, 16+ stall cycles) → the counter holds at 15.
